// File: rtl/sram_ctrl.sv
// sram_ctrl: request-side controller for a single-port synchronous SRAM macro.
//
// Accepts single-word writes and incrementing read bursts over a valid/ready
// request channel. Drives the macro CS/WE/addr/data_in pins. Returns read beats
// over a valid/ready response channel that supports backpressure.
//
// Build option: define SRAM_CTRL_WR_COMP_EN to pre-subtract WR_OFFSET from the
// write address. The macro adds WR_OFFSET on writes, so with this option a
// write to A lands in the word that a read of A returns. Read addresses are
// never modified.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   req_valid/req_ready        request handshake
//   req_we, req_addr, req_len  1=write / 0=read burst, word address, beats-1
//   req_wdata                  write data
//   rsp_valid/rsp_ready        response handshake
//   rsp_data, rsp_last         read beat data, final beat of the burst
//   busy                       controller not idle
//   sram_cs, sram_we           macro strobes
//   sram_addr, sram_wdata      macro address / write data (hold between strobes)
//   sram_rdata                 macro read data (valid the cycle after a read strobe)
//
// States:
//   IDLE     | ready for a request
//   WRITE    | one-cycle write strobe
//   RD_ISSUE | one-cycle read strobe at the current address
//   RD_WAIT  | macro output settles, captured into rsp_data
//   RD_RESP  | beat presented, waiting for rsp_ready

module sram_ctrl #(
    parameter int ADDR      = 8,
    parameter int WIDTH     = 32,
    parameter int LEN_W     = 4,
    parameter int WR_OFFSET = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [ADDR-1:0]  req_addr,
    input  logic [LEN_W-1:0] req_len,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_last,
    output logic             busy,
    output logic             sram_cs,
    output logic             sram_we,
    output logic [ADDR-1:0]  sram_addr,
    output logic [WIDTH-1:0] sram_wdata,
    input  logic [WIDTH-1:0] sram_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        RD_ISSUE,
        RD_WAIT,
        RD_RESP
    } state_t;

`ifdef SRAM_CTRL_WR_COMP_EN
    localparam bit WR_COMP = 1'b1;
`else
    localparam bit WR_COMP = 1'b0;
`endif

    state_t           state, state_nxt;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt_q;
    logic [ADDR-1:0]  addr_q;
    logic [WIDTH-1:0] wdata_q;
    logic [WIDTH-1:0] rdata_q;
    logic [ADDR-1:0]  wr_addr;
    logic             accept;
    logic             last_beat;
    logic             beat_done;

    // Modulo-2^ADDR subtraction falls out of the fixed-width arithmetic.
    assign wr_addr   = WR_COMP ? (req_addr - ADDR'(WR_OFFSET)) : req_addr;
    assign accept    = (state == IDLE) && req_valid;
    assign last_beat = (cnt_q == len_q);
    assign beat_done = (state == RD_RESP) && rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        sram_cs   = 1'b0;
        sram_we   = 1'b0;
        rsp_valid = 1'b0;
        rsp_last  = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    state_nxt = req_we ? WRITE : RD_ISSUE;
                end
            end
            WRITE: begin
                sram_cs   = 1'b1;
                sram_we   = 1'b1;
                state_nxt = IDLE;
            end
            RD_ISSUE: begin
                sram_cs   = 1'b1;
                state_nxt = RD_WAIT;
            end
            RD_WAIT: begin
                state_nxt = RD_RESP;
            end
            RD_RESP: begin
                rsp_valid = 1'b1;
                rsp_last  = last_beat;
                if (rsp_ready) begin
                    state_nxt = last_beat ? IDLE : RD_ISSUE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // addr_q doubles as the macro address pin: it is only rewritten on accept
    // or beat advance, so it holds its value outside the strobe states.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                len_q <= req_len;
                cnt_q <= '0;
                if (req_we) begin
                    addr_q  <= wr_addr;
                    wdata_q <= req_wdata;
                end else begin
                    addr_q <= req_addr;
                end
            end
            if (state == RD_WAIT) begin
                rdata_q <= sram_rdata;
            end
            if (beat_done && !last_beat) begin
                addr_q <= addr_q + 1'b1;
                cnt_q  <= cnt_q + 1'b1;
            end
        end
    end

    assign sram_addr  = addr_q;
    assign sram_wdata = wdata_q;
    assign rsp_data   = rdata_q;

endmodule

// File: tb/tb_sram_ctrl.sv
module tb_sram_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [7:0]  req_addr;
    logic [3:0]  req_len;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_last;
    logic        busy;
    logic        sram_cs;
    logic        sram_we;
    logic [7:0]  sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

`ifdef SRAM_CTRL_WR_COMP_EN
    localparam bit         COMP      = 1'b1;
    localparam logic [7:0] MODEL_OFF = 8'd15;
`else
    localparam bit         COMP      = 1'b0;
    localparam logic [7:0] MODEL_OFF = 8'd0;
`endif

    sram_ctrl #(.ADDR(8), .WIDTH(32), .LEN_W(4), .WR_OFFSET(15)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_len    (req_len),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_last   (rsp_last),
        .busy       (busy),
        .sram_cs    (sram_cs),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM macro model: adds MODEL_OFF to write addresses, read data appears
    // the cycle after the strobe and holds until the next read strobe.
    logic [31:0] mem [256];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hC0FFEE00 | i;
        mem[8'h20] = 32'h12345678;
        sram_rdata = '0;
        forever begin
            @(posedge clk);
            if (sram_cs) begin
                if (sram_we) mem[8'(sram_addr + MODEL_OFF)] = sram_wdata;
                else sram_rdata <= mem[sram_addr];
            end
        end
    end

    // Monitor, sampled on the falling edge.
    logic [7:0]  st_addr [$];
    logic        st_we [$];
    logic [31:0] st_wdata [$];
    logic [31:0] bt_data [$];
    logic        bt_last [$];

    always @(negedge clk) begin
        if (sram_cs) begin
            st_addr.push_back(sram_addr);
            st_we.push_back(sram_we);
            st_wdata.push_back(sram_wdata);
        end
        if (rsp_valid && rsp_ready) begin
            bt_data.push_back(rsp_data);
            bt_last.push_back(rsp_last);
        end
    end

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        st_addr.delete();
        st_we.delete();
        st_wdata.delete();
        bt_data.delete();
        bt_last.delete();
    endtask

    typedef struct {
        logic        we;
        logic [7:0]  addr;
        logic [3:0]  len;
        logic [31:0] wdata;
        logic [7:0]  exp_sa_raw;
        logic [7:0]  exp_sa_comp;
        int          exp_beats;
        logic [31:0] exp_first;
        logic [31:0] exp_last;
    } vec_t;

    localparam int NV = 8;
    vec_t vecs [NV];

    initial begin
        vec_t        v;
        int          k;
        int          seq_err;
        int          ready_err;
        int          stall;
        int          stall_err;
        int          nbeat;
        int          st_at_stall;
        int          st_after;
        bit          done;
        logic [31:0] stall_data;
        logic [7:0]  exp_sa;

        //             we    addr   len   wdata          raw    comp   beats first          last
        vecs[0] = '{1'b1, 8'h10, 4'd0, 32'hDEADBEEF, 8'h10, 8'h01, 0, 32'h0,        32'h0};
        vecs[1] = '{1'b0, 8'h20, 4'd0, 32'h0,        8'h20, 8'h20, 1, 32'h12345678, 32'h12345678};
        vecs[2] = '{1'b1, 8'h30, 4'd0, 32'hA5A5A5A5, 8'h30, 8'h21, 0, 32'h0,        32'h0};
        vecs[3] = '{1'b0, 8'h30, 4'd0, 32'h0,        8'h30, 8'h30, 1, 32'hA5A5A5A5, 32'hA5A5A5A5};
        vecs[4] = '{1'b0, 8'h40, 4'd2, 32'h0,        8'h40, 8'h40, 3, 32'hC0FFEE40, 32'hC0FFEE42};
        vecs[5] = '{1'b0, 8'hF8, 4'd15,32'h0,        8'hF8, 8'hF8, 16,32'hC0FFEEF8, 32'hC0FFEE07};
        vecs[6] = '{1'b0, 8'h10, 4'd1, 32'h0,        8'h10, 8'h10, 2, 32'hDEADBEEF, 32'hC0FFEE11};
        vecs[7] = '{1'b1, 8'h05, 4'd0, 32'h01020304, 8'h05, 8'hF6, 0, 32'h0,        32'h0};

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_len   = '0;
        req_wdata = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_rsp", {rsp_valid, rsp_last, rsp_data}, 34'h0);
        chk("rst_sram", {sram_cs, sram_we, sram_addr, sram_wdata}, 42'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table-driven single transactions, rsp_ready held high.
        for (int i = 0; i < NV; i++) begin
            v = vecs[i];
            clear_mon();
            exp_sa = COMP ? v.exp_sa_comp : v.exp_sa_raw;
            req_we    = v.we;
            req_addr  = v.addr;
            req_len   = v.len;
            req_wdata = v.wdata;
            req_valid = 1'b1;
            chk($sformatf("v%0d_ready_pre", i), req_ready, 1);
            @(posedge clk);
            #1;
            req_valid = 1'b0;
            if (v.we) begin
                chk($sformatf("v%0d_wr_ready_n1", i), req_ready, 0);
                @(posedge clk);
                #1;
                chk($sformatf("v%0d_wr_ready_n2", i), req_ready, 1);
                chk($sformatf("v%0d_wr_strobes", i), st_addr.size(), 1);
                if (st_addr.size() > 0) begin
                    chk($sformatf("v%0d_wr_addr", i), st_addr[0], exp_sa);
                    chk($sformatf("v%0d_wr_we", i), st_we[0], 1);
                    chk($sformatf("v%0d_wr_data", i), st_wdata[0], v.wdata);
                end
            end else begin
                k = 0;
                while (!rsp_valid && k < 20) begin
                    @(posedge clk);
                    #1;
                    k++;
                end
                chk($sformatf("v%0d_rd_latency", i), k + 1, 3);
                k = 0;
                while (!(bt_last.size() > 0 && bt_last[$]) && k < 200) begin
                    @(posedge clk);
                    #1;
                    k++;
                end
                @(posedge clk);
                #1;
                chk($sformatf("v%0d_rd_idle", i), busy, 0);
                chk($sformatf("v%0d_rd_strobes", i), st_addr.size(), v.exp_beats);
                chk($sformatf("v%0d_rd_beats", i), bt_data.size(), v.exp_beats);
                seq_err = 0;
                for (int j = 0; j < st_addr.size(); j++) begin
                    if (st_addr[j] !== 8'(exp_sa + j) || st_we[j] !== 1'b0) seq_err++;
                end
                chk($sformatf("v%0d_rd_addr_seq", i), seq_err, 0);
                if (bt_data.size() > 0) begin
                    chk($sformatf("v%0d_rd_first", i), bt_data[0], v.exp_first);
                    chk($sformatf("v%0d_rd_last_data", i), bt_data[$], v.exp_last);
                    chk($sformatf("v%0d_rd_last_flag", i), bt_last[$], 1);
                end
            end
        end

        // Burst len=3 from 0xFE, beat 2 stalled 5 cycles, a write request
        // held valid throughout the burst.
        clear_mon();
        req_we    = 1'b0;
        req_addr  = 8'hFE;
        req_len   = 4'd3;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_we    = 1'b1;
        req_addr  = 8'h50;
        req_len   = 4'd0;
        req_wdata = 32'h55AA55AA;
        ready_err   = 0;
        stall       = 0;
        stall_err   = 0;
        nbeat       = 0;
        done        = 1'b0;
        st_at_stall = -1;
        st_after    = -2;
        stall_data  = '0;
        k = 0;
        while (!done && k < 200) begin
            if (req_ready) ready_err++;
            if (rsp_valid && nbeat == 1 && stall < 5) begin
                rsp_ready = 1'b0;
                if (stall == 0) begin
                    stall_data  = rsp_data;
                    st_at_stall = st_addr.size();
                end else if (rsp_data !== stall_data || !rsp_valid || rsp_last) begin
                    stall_err++;
                end
                stall++;
            end else begin
                rsp_ready = 1'b1;
                if (rsp_valid) begin
                    if (nbeat == 1) st_after = st_addr.size();
                    if (rsp_last) done = 1'b1;
                    nbeat++;
                end
            end
            @(posedge clk);
            #1;
            k++;
        end
        chk("stall_ready_low", ready_err, 0);
        chk("stall_cycles", stall, 5);
        chk("stall_data_stable", stall_err, 0);
        chk("stall_strobes_at_start", st_at_stall, 2);
        chk("stall_no_strobe", st_after, st_at_stall);
        chk("stall_ready_after_last", req_ready, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("stall_strobe_cnt", st_addr.size(), 5);
        chk("stall_beat_cnt", bt_data.size(), 4);
        if (st_addr.size() >= 5) begin
            chk("stall_rd_addrs", {st_addr[0], st_addr[1], st_addr[2], st_addr[3]}, 32'hFEFF0001);
            chk("stall_we_flags", {st_we[0], st_we[1], st_we[2], st_we[3], st_we[4]}, 5'b00001);
            chk("held_wr_addr", st_addr[4], COMP ? 8'h41 : 8'h50);
            chk("held_wr_data", st_wdata[4], 32'h55AA55AA);
        end
        if (bt_data.size() >= 4) begin
            chk("stall_last_flags", {bt_last[0], bt_last[1], bt_last[2], bt_last[3]}, 4'b0001);
            chk("stall_data_b0", bt_data[0], 32'hC0FFEEFE);
            chk("stall_data_b1", bt_data[1], 32'hC0FFEEFF);
            chk("stall_data_b2", bt_data[2], 32'hC0FFEE00);
            chk("stall_data_b3", bt_data[3], 32'hC0FFEE01);
        end

        // Reset in the middle of a 16-beat burst.
        clear_mon();
        rsp_ready = 1'b1;
        req_we    = 1'b0;
        req_addr  = 8'h00;
        req_len   = 4'd15;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        chk("pre_rst_strobes", st_addr.size(), 3);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req_ready", req_ready, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_rsp", {rsp_valid, rsp_last, rsp_data}, 34'h0);
        chk("mid_rst_sram", {sram_cs, sram_we, sram_addr, sram_wdata}, 42'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clear_mon();
        repeat (10) @(posedge clk);
        #1;
        chk("post_rst_no_strobe", st_addr.size(), 0);
        chk("post_rst_req_ready", req_ready, 1);
        chk("post_rst_rsp_valid", rsp_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
